// File: rtl/stream_buffer_pkg.sv
// Shared k-means datapath definitions: buffer FSM states and default sizing.
package stream_buffer_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 4096;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    READ = 2'd2
  } state_e;

endpackage

// File: rtl/stream_buffer_ram.sv
// Single-port synchronous RAM, write-first, one-cycle registered read.
module stream_buffer_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
      rdata_q       <= wdata_i;
    end else begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/stream_buffer.sv
// Load/replay sample buffer: captures a burst into RAM, then streams it back
// in order after the load (optional) and on every rd_start request.
module stream_buffer
  import stream_buffer_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int AUTO_REPLAY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              rd_start,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              busy
);

  localparam int             CW   = ADDR_W + 1;
  localparam logic [ADDR_W:0] FULL = CW'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                pipe_valid_q, pipe_valid_d;
  logic                pipe_last_q, pipe_last_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic                flush;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_rdata;
  logic [ADDR_W:0]     count_m1;
  logic                rd_is_last;

  assign count_m1   = count_q - CW'(1);
  assign rd_is_last = ({1'b0, rd_addr_q} == count_m1);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    rd_addr_d    = rd_addr_q;
    pipe_valid_d = 1'b0;
    pipe_last_d  = 1'b0;
    flush        = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = rd_addr_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d    = LOAD;
          ram_we     = 1'b1;
          ram_addr   = '0;
          count_d    = CW'(1);
          overflow_d = 1'b0;
        end else if (rd_start && (count_q != '0)) begin
          state_d   = READ;
          rd_addr_d = '0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          // Words past capacity are dropped and flagged, count saturates.
          if (count_q == FULL) begin
            overflow_d = 1'b1;
          end else begin
            ram_we   = 1'b1;
            ram_addr = count_q[ADDR_W-1:0];
            count_d  = count_q + CW'(1);
          end
        end else begin
          state_d   = (AUTO_REPLAY != 0) ? READ : IDLE;
          rd_addr_d = '0;
        end
      end
      READ: begin
        if (in_valid) begin
          // Abort: new burst replaces the pass, in-flight words are dropped.
          state_d    = LOAD;
          ram_we     = 1'b1;
          ram_addr   = '0;
          count_d    = CW'(1);
          overflow_d = 1'b0;
          flush      = 1'b1;
        end else begin
          pipe_valid_d = 1'b1;
          pipe_last_d  = rd_is_last;
          if (rd_is_last) begin
            state_d = IDLE;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = pipe_valid_q && !flush;
    out_last_d  = pipe_last_q && !flush;
    out_data_d  = out_valid_d ? ram_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      rd_addr_q    <= '0;
      pipe_valid_q <= 1'b0;
      pipe_last_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      rd_addr_q    <= rd_addr_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_last_q  <= pipe_last_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
    end
  end

  stream_buffer_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (in_data),
    .rdata_o (ram_rdata)
  );

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_stream_buffer.sv
// Directed bench for stream_buffer: default instance plus a DEPTH=8,
// AUTO_REPLAY=0 instance for overflow and collision sequences.
module tb_stream_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_in_valid, a_rd_start;
  logic [15:0] a_in_data;
  logic        a_out_valid, a_out_last, a_overflow, a_busy;
  logic [15:0] a_out_data;
  logic [12:0] a_count;

  logic        b_in_valid, b_rd_start;
  logic [15:0] b_in_data;
  logic        b_out_valid, b_out_last, b_overflow, b_busy;
  logic [15:0] b_out_data;
  logic [3:0]  b_count;

  stream_buffer dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_data(a_in_data),
    .rd_start(a_rd_start), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_last(a_out_last), .count(a_count), .overflow(a_overflow), .busy(a_busy)
  );

  stream_buffer #(.DEPTH(8), .AUTO_REPLAY(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_data(b_in_data),
    .rd_start(b_rd_start), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_last(b_out_last), .count(b_count), .overflow(b_overflow), .busy(b_busy)
  );

  bit          sel;
  logic        obs_valid, obs_last, obs_overflow, obs_busy;
  logic [15:0] obs_data;
  logic [12:0] obs_count;

  assign obs_valid    = sel ? b_out_valid : a_out_valid;
  assign obs_last     = sel ? b_out_last  : a_out_last;
  assign obs_data     = sel ? b_out_data  : a_out_data;
  assign obs_overflow = sel ? b_overflow  : a_overflow;
  assign obs_busy     = sel ? b_busy      : a_busy;
  assign obs_count    = sel ? {9'd0, b_count} : a_count;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller has already applied the trigger edge; first word is lat edges later.
  task automatic check_stream(input bit s, input int lat, input int n,
                              input logic [15:0] first, input string name);
    logic [15:0] w_exp;
    sel = s;
    for (int k = 1; k < lat; k++) begin
      tick();
      chk($sformatf("%s_lat%0d", name, k), {31'd0, obs_valid}, 32'd0);
    end
    for (int w = 0; w < n; w++) begin
      tick();
      w_exp = first + 16'(w);
      $display("[TB] %s word %0d: valid=%0b data=0x%0h last=%0b", name, w,
               obs_valid, obs_data, obs_last);
      chk($sformatf("%s_valid%0d", name, w), {31'd0, obs_valid}, 32'd1);
      chk($sformatf("%s_data%0d", name, w), {16'd0, obs_data}, {16'd0, w_exp});
      chk($sformatf("%s_last%0d", name, w), {31'd0, obs_last}, (w == n - 1) ? 32'd1 : 32'd0);
    end
    tick();
    chk($sformatf("%s_end", name), {31'd0, obs_valid}, 32'd0);
  endtask

  task automatic expect_quiet(input bit s, input int cycles, input string name);
    int seen;
    sel  = s;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (obs_valid) seen++;
    end
    chk(name, seen, 0);
  endtask

  typedef struct {
    logic        iv;
    logic [15:0] d;
    logic        rs;
    logic        ev;
    logic [15:0] ed;
    logic        el;
    logic [12:0] ec;
    logic        eb;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [15:0] d, input logic rs,
                              input logic ev, input logic [15:0] ed, input logic el,
                              input logic [12:0] ec, input logic eb);
    vec_t v;
    v.iv = iv; v.d = d; v.rs = rs; v.ev = ev; v.ed = ed; v.el = el; v.ec = ec; v.eb = eb;
    return v;
  endfunction

  vec_t vecs[15];

  initial begin
    // Row i: inputs sampled at edge i, outputs expected just after edge i.
    vecs[0]  = mk(1'b1, 16'd1024, 1'b0, 1'b0, 16'd0,    1'b0, 13'd1, 1'b1);
    vecs[1]  = mk(1'b1, 16'd512,  1'b0, 1'b0, 16'd0,    1'b0, 13'd2, 1'b1);
    vecs[2]  = mk(1'b0, 16'd0,    1'b0, 1'b0, 16'd0,    1'b0, 13'd2, 1'b1);
    vecs[3]  = mk(1'b0, 16'd0,    1'b0, 1'b0, 16'd0,    1'b0, 13'd2, 1'b1);
    vecs[4]  = mk(1'b0, 16'd0,    1'b0, 1'b1, 16'd1024, 1'b0, 13'd2, 1'b0);
    vecs[5]  = mk(1'b0, 16'd0,    1'b0, 1'b1, 16'd512,  1'b1, 13'd2, 1'b0);
    vecs[6]  = mk(1'b0, 16'd0,    1'b0, 1'b0, 16'd0,    1'b0, 13'd2, 1'b0);
    vecs[7]  = mk(1'b0, 16'd0,    1'b1, 1'b0, 16'd0,    1'b0, 13'd2, 1'b1);
    vecs[8]  = mk(1'b0, 16'd0,    1'b0, 1'b0, 16'd0,    1'b0, 13'd2, 1'b1);
    vecs[9]  = mk(1'b0, 16'd0,    1'b0, 1'b1, 16'd1024, 1'b0, 13'd2, 1'b0);
    vecs[10] = mk(1'b0, 16'd0,    1'b1, 1'b1, 16'd512,  1'b1, 13'd2, 1'b1);
    vecs[11] = mk(1'b0, 16'd0,    1'b0, 1'b0, 16'd0,    1'b0, 13'd2, 1'b1);
    vecs[12] = mk(1'b0, 16'd0,    1'b0, 1'b1, 16'd1024, 1'b0, 13'd2, 1'b0);
    vecs[13] = mk(1'b0, 16'd0,    1'b0, 1'b1, 16'd512,  1'b1, 13'd2, 1'b0);
    vecs[14] = mk(1'b0, 16'd0,    1'b0, 1'b0, 16'd0,    1'b0, 13'd2, 1'b0);

    sel        = 1'b0;
    rst_n      = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_rd_start = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_rd_start = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset state of both instances
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      chk($sformatf("rst_valid_%0d", s), {31'd0, obs_valid}, 32'd0);
      chk($sformatf("rst_data_%0d", s), {16'd0, obs_data}, 32'd0);
      chk($sformatf("rst_last_%0d", s), {31'd0, obs_last}, 32'd0);
      chk($sformatf("rst_count_%0d", s), {19'd0, obs_count}, 32'd0);
      chk($sformatf("rst_ovf_%0d", s), {31'd0, obs_overflow}, 32'd0);
      chk($sformatf("rst_busy_%0d", s), {31'd0, obs_busy}, 32'd0);
    end

    // rd_start with nothing stored is ignored
    a_rd_start = 1'b1;
    tick();
    a_rd_start = 1'b0;
    expect_quiet(1'b0, 10, "empty_rdstart");

    // Basic load/auto-replay, replay on request, back-to-back request
    sel = 1'b0;
    for (int i = 0; i < 15; i++) begin
      a_in_valid = vecs[i].iv;
      a_in_data  = vecs[i].d;
      a_rd_start = vecs[i].rs;
      tick();
      $display("[TB] vec %0d: valid=%0b data=0x%0h last=%0b count=%0d busy=%0b", i,
               a_out_valid, a_out_data, a_out_last, a_count, a_busy);
      chk($sformatf("vec%0d_valid", i), {31'd0, a_out_valid}, {31'd0, vecs[i].ev});
      chk($sformatf("vec%0d_data", i), {16'd0, a_out_data}, {16'd0, vecs[i].ed});
      chk($sformatf("vec%0d_last", i), {31'd0, a_out_last}, {31'd0, vecs[i].el});
      chk($sformatf("vec%0d_count", i), {19'd0, a_count}, {19'd0, vecs[i].ec});
      chk($sformatf("vec%0d_busy", i), {31'd0, a_busy}, {31'd0, vecs[i].eb});
    end
    a_in_valid = 1'b0; a_rd_start = 1'b0;

    // Abort a pass after 3 words with a new single-word load
    for (int i = 0; i < 16; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 16'h0100 + 16'(i);
      tick();
    end
    a_in_valid = 1'b0;
    chk("abort_count16", {19'd0, a_count}, 32'd16);
    tick();
    tick();
    chk("abort_lat", {31'd0, a_out_valid}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("abort_pre_valid%0d", k), {31'd0, a_out_valid}, 32'd1);
      chk($sformatf("abort_pre_data%0d", k), {16'd0, a_out_data}, 32'h0100 + k);
    end
    a_in_valid = 1'b1;
    a_in_data  = 16'hAAAA;
    tick();
    a_in_valid = 1'b0;
    chk("abort_valid", {31'd0, a_out_valid}, 32'd0);
    chk("abort_last", {31'd0, a_out_last}, 32'd0);
    chk("abort_count", {19'd0, a_count}, 32'd1);
    tick();
    check_stream(1'b0, 2, 1, 16'hAAAA, "abort_replay");

    // Overflow on DEPTH=8 (AUTO_REPLAY=0): words 1..10
    sel = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = 16'(i + 1);
      tick();
      if (i == 7) begin
        chk("ovf_full_count", {28'd0, b_count}, 32'd8);
        chk("ovf_full_flag", {31'd0, b_overflow}, 32'd0);
      end
    end
    b_in_valid = 1'b0;
    tick();
    chk("ovf_count", {28'd0, b_count}, 32'd8);
    chk("ovf_flag", {31'd0, b_overflow}, 32'd1);
    chk("ovf_busy", {31'd0, b_busy}, 32'd0);
    expect_quiet(1'b1, 5, "ovf_no_auto");
    b_rd_start = 1'b1;
    tick();
    b_rd_start = 1'b0;
    check_stream(1'b1, 2, 8, 16'd1, "ovf_replay");

    // Load wins over a simultaneous rd_start; only new words are replayed
    b_in_valid = 1'b1;
    b_rd_start = 1'b1;
    b_in_data  = 16'h0031;
    tick();
    b_rd_start = 1'b0;
    chk("coll_busy", {31'd0, b_busy}, 32'd1);
    chk("coll_count1", {28'd0, b_count}, 32'd1);
    chk("coll_ovf", {31'd0, b_overflow}, 32'd0);
    b_in_data = 16'h0032;
    tick();
    b_in_data = 16'h0033;
    tick();
    b_in_valid = 1'b0;
    tick();
    chk("coll_count3", {28'd0, b_count}, 32'd3);
    expect_quiet(1'b1, 5, "coll_no_auto");
    b_rd_start = 1'b1;
    tick();
    b_rd_start = 1'b0;
    check_stream(1'b1, 2, 3, 16'h0031, "coll_replay");

    // Reset in the middle of a full-depth pass
    sel = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 16'(i);
      tick();
    end
    a_in_valid = 1'b0;
    chk("full_count", {19'd0, a_count}, 32'd4096);
    chk("full_ovf", {31'd0, a_overflow}, 32'd0);
    tick();
    tick();
    tick();
    chk("full_w0_valid", {31'd0, a_out_valid}, 32'd1);
    chk("full_w0_data", {16'd0, a_out_data}, 32'd0);
    tick();
    chk("full_w1_data", {16'd0, a_out_data}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, a_out_valid}, 32'd0);
    chk("arst_data", {16'd0, a_out_data}, 32'd0);
    chk("arst_last", {31'd0, a_out_last}, 32'd0);
    chk("arst_busy", {31'd0, a_busy}, 32'd0);
    chk("arst_count", {19'd0, a_count}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_count", {19'd0, a_count}, 32'd0);
    a_rd_start = 1'b1;
    tick();
    a_rd_start = 1'b0;
    chk("post_rst_busy", {31'd0, a_busy}, 32'd0);
    expect_quiet(1'b0, 10, "post_rst_rdstart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
